tensor_weight_feeder: RTL and testbench
=======================================

// Module: tensor_weight_feeder
// PURPOSE
//  Transmit side of the tensor-block ping-pong weight-load protocol. Buffers
//  80-bit weight rows from an upstream valid/ready stream, groups them ROWS at
//  a time, and drives load_bank_1 / load_bank_2 and cascade_out into the
//  tensor-block array. Banks are filled alternately (1,2,1,2...), and the
//  feeder never overwrites a bank that compute still holds.
// PARAMETERS
//  DATA_W      80  cascade word width (10 x 8-bit weights)
//  ROWS        3   words per bank load (one per tensor column)
//  FIFO_DEPTH  8   input buffer depth in words; must be >= ROWS, power of 2
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  s_data         in   DATA_W  upstream weight word
//  s_valid        in   1       s_data valid
//  s_ready        out  1       feeder accepts s_data this cycle
//  bank_busy      in   2       [0]=bank1, [1]=bank2 held by compute; do not load
//  load_bank_1    out  1       cascade word in the NEXT cycle belongs to bank 1
//  load_bank_2    out  1       cascade word in the NEXT cycle belongs to bank 2
//  cascade_out    out  DATA_W  weight word to tensor-block cascade_in
//  cascade_valid  out  1       cascade_out carries a weight word this cycle
//  bank_loaded    out  2       1-cycle pulse: [0]=bank1 / [1]=bank2 fully loaded
//  next_bank      out  1       0=bank 1 is next target, 1=bank 2 is next target
// BEHAVIOUR
//  Reset: all outputs 0 (next_bank=0, i.e. bank 1 first); FIFO empty; FSM IDLE.
//  FIFO: push on s_valid&&s_ready; s_ready = (count < FIFO_DEPTH), using the
//   registered count, so a pop in the same cycle does not raise s_ready early.
//   Simultaneous push and pop leaves count unchanged. Pointers wrap mod FIFO_DEPTH.
//  FSM states IDLE, LOAD. Index k counts 0..ROWS-1.
//   IDLE->LOAD when count >= ROWS && !bank_busy[next_bank]; entered at cycle T.
//   LOAD: load_bank_{next_bank+1}=1 in cycles T..T+ROWS-1 and the other flag=0.
//    Each LOAD cycle pops one word into the cascade register, so
//    cascade_out = word k and cascade_valid=1 in cycle T+1+k (1-cycle lag).
//   When k=ROWS-1: next_bank toggles. If count-1 >= ROWS and the new target is
//    not busy, stay in LOAD and start the next group at T+ROWS with no gap. The
//    new flag is then high in the same cycle as the previous group's last word.
//    Otherwise go to IDLE.
//  bank_loaded[b] pulses in the cycle the last word (k=ROWS-1) is on cascade_out.
//  load_bank_1 and load_bank_2 are never high together.
//  cascade_out = 0 whenever cascade_valid=0.
//  bank_busy is sampled only on the IDLE->LOAD or group-to-group decision. A
//   change during a group does not abort it.
//  A partial group (count < ROWS) never starts. Words stay in the FIFO.
//  Reset mid-group: immediate clear. The partial load is lost; bank 1 is next.
// TESTING
//  1 Push 01..,02..,03.. (each byte = value) from reset -> load_bank_1 high
//    T..T+2; cascade_out 0x0101..,0x0202..,0x0303.. at T+1..T+3;
//    bank_loaded=01 at T+3.
//  2 Push six words 1..6 back-to-back -> load_bank_1 at T..T+2 then
//    load_bank_2 at T+3..T+5; cascade_valid continuous T+1..T+6;
//    bank_loaded=10 at T+6.
//  3 Push two words only -> no load flag, cascade_valid=0. Push the third ->
//    group starts next cycle.
//  4 bank_busy=01 with next_bank=0 and 3 words queued -> stays IDLE. Drop
//    bank_busy -> load_bank_1 asserts the next cycle.
//  5 Hold s_valid with no drain (bank_busy=11) -> s_ready falls after 8 pushes.
//    Push+pop in the same cycle keeps count fixed.
//  6 Assert rst_n=0 at T+1 of a group -> all outputs 0 asynchronously. After
//    release, next_bank=0 and the FIFO is empty.

Source files
------------

// File: rtl/tensor_weight_feeder.sv
// tensor_weight_feeder
//   Transmit side of the ping-pong weight-load protocol. Buffers DATA_W-bit
//   weight rows in a small FIFO and streams them ROWS at a time into
//   alternating tensor-block banks (1,2,1,2...). A bank still held by compute
//   is never targeted.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   s_data/s_valid  upstream weight word and its valid
//   s_ready         word accepted when s_valid && s_ready
//   bank_busy       [0]=bank1, [1]=bank2 held by compute
//   load_bank_1/2   cascade word in the next cycle belongs to bank 1 / bank 2
//   cascade_out     weight word to cascade_in (0 when cascade_valid=0)
//   cascade_valid   cascade_out carries a word this cycle
//   bank_loaded     1-cycle pulse when the last word of a bank is on cascade_out
//   next_bank       0: bank 1 is the next/current target, 1: bank 2
module tensor_weight_feeder #(
    parameter int unsigned DATA_W     = 80,
    parameter int unsigned ROWS       = 3,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [1:0]        bank_busy,
    output logic              load_bank_1,
    output logic              load_bank_2,
    output logic [DATA_W-1:0] cascade_out,
    output logic              cascade_valid,
    output logic [1:0]        bank_loaded,
    output logic              next_bank
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned KW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_nx;
    logic [KW-1:0]     k, k_nx;

    logic              bank_nx;
    logic [1:0]        loaded_nx;
    logic              load1_nx, load2_nx;
    logic [DATA_W-1:0] cascade_nx;
    logic              ready_nx;
    logic              push, pop;

    // Handshake and drain: every LOAD cycle moves one word to the cascade register
    always_comb begin
        push = s_valid && s_ready;
        pop  = (state == LOAD);
    end

    // FIFO storage (no reset needed; validity tracked by count)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx  = state;
        k_nx      = k;
        bank_nx   = next_bank;
        loaded_nx = 2'b00;

        case (state)
            IDLE: begin
                if (count >= CW'(ROWS) && !bank_busy[next_bank]) begin
                    state_nx = LOAD;
                    k_nx     = '0;
                end
            end
            LOAD: begin
                if (k == KW'(ROWS - 1)) begin
                    k_nx      = '0;
                    bank_nx   = ~next_bank;
                    loaded_nx = next_bank ? 2'b10 : 2'b01;
                    // Back-to-back group only if a full group remains after this pop
                    if (count >= CW'(ROWS + 1) && !bank_busy[bank_nx]) begin
                        state_nx = LOAD;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    k_nx = k + KW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        case ({push, pop})
            2'b10:   count_nx = count + CW'(1);
            2'b01:   count_nx = count - CW'(1);
            default: count_nx = count;
        endcase

        cascade_nx = pop ? mem[rd_ptr] : '0;
        load1_nx   = (state_nx == LOAD) && !bank_nx;
        load2_nx   = (state_nx == LOAD) && bank_nx;
        ready_nx   = (count_nx < CW'(FIFO_DEPTH));
    end

    // State, FIFO bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            k             <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            next_bank     <= 1'b0;
            bank_loaded   <= 2'b00;
            load_bank_1   <= 1'b0;
            load_bank_2   <= 1'b0;
            cascade_out   <= '0;
            cascade_valid <= 1'b0;
            s_ready       <= 1'b0;
        end else begin
            state         <= state_nx;
            k             <= k_nx;
            count         <= count_nx;
            next_bank     <= bank_nx;
            bank_loaded   <= loaded_nx;
            load_bank_1   <= load1_nx;
            load_bank_2   <= load2_nx;
            cascade_out   <= cascade_nx;
            cascade_valid <= pop;
            s_ready       <= ready_nx;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tensor_weight_feeder.sv
// Bench for tensor_weight_feeder: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_tensor_weight_feeder;

    localparam int DW    = 80;
    localparam int ROWS  = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [1:0]    bank_busy = 2'b00;
    logic          load_bank_1, load_bank_2;
    logic [DW-1:0] cascade_out;
    logic          cascade_valid;
    logic [1:0]    bank_loaded;
    logic          next_bank;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    tensor_weight_feeder #(.DATA_W(DW), .ROWS(ROWS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .bank_busy(bank_busy),
        .load_bank_1(load_bank_1), .load_bank_2(load_bank_2),
        .cascade_out(cascade_out), .cascade_valid(cascade_valid),
        .bank_loaded(bank_loaded), .next_bank(next_bank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        return {10{b}};
    endfunction

    // Reference model: a word queue, the words left in the current group and
    // the target bank. Expected outputs are what must be visible after each edge.
    logic [DW-1:0] mq[$];
    int            grp_left = 0;
    logic          tgt = 1'b0;
    logic          e_l1 = 0, e_l2 = 0, e_cv = 0, e_nb = 0, e_sr = 0;
    logic [DW-1:0] e_co = '0;
    logic [1:0]    e_bl = 2'b00;

    initial begin
        int  sz;
        bit  pushed;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                grp_left = 0; tgt = 0;
                e_l1 = 0; e_l2 = 0; e_cv = 0; e_nb = 0; e_sr = 0;
                e_co = '0; e_bl = 2'b00;
            end else begin
                pushed = s_valid && e_sr;
                sz = mq.size();
                if (grp_left > 0) begin
                    e_cv = 1;
                    e_co = mq.pop_front();
                    e_bl = (grp_left == 1) ? (tgt ? 2'b10 : 2'b01) : 2'b00;
                end else begin
                    e_cv = 0; e_co = '0; e_bl = 2'b00;
                end
                if (grp_left > 1) begin
                    grp_left--;
                end else if (grp_left == 1) begin
                    tgt = !tgt;
                    grp_left = (sz - 1 >= ROWS && !bank_busy[tgt]) ? ROWS : 0;
                end else if (sz >= ROWS && !bank_busy[tgt]) begin
                    grp_left = ROWS;
                end
                if (pushed) mq.push_back(s_data);
                e_l1 = (grp_left > 0) && !tgt;
                e_l2 = (grp_left > 0) && tgt;
                e_nb = tgt;
                e_sr = (mq.size() < DEPTH);
            end
        end
    end

    // Per-cycle compare, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("m_s_ready",       s_ready,       e_sr);
                chk("m_load_bank_1",   load_bank_1,   e_l1);
                chk("m_load_bank_2",   load_bank_2,   e_l2);
                chk("m_cascade_valid", cascade_valid, e_cv);
                chk("m_cascade_out",   cascade_out,   e_co);
                chk("m_bank_loaded",   bank_loaded,   e_bl);
                chk("m_next_bank",     next_bank,     e_nb);
                if (load_bank_1 && load_bank_2) chk("m_both_flags", 1, 0);
            end
        end
    end

    task automatic do_reset();
        s_valid = 0;
        bank_busy = 2'b00;
        rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    // Hold word on s_data until accepted (called at a falling edge)
    task automatic push(input logic [DW-1:0] w);
        bit rdy;
        s_data = w;
        s_valid = 1;
        for (int i = 0; i < 50; i++) begin
            rdy = s_ready;
            @(negedge clk);
            if (rdy) return;
        end
        chk("push_timeout", 0, 1);
    endtask

    task automatic wait_lb1(input string name);
        for (int i = 0; i < 30; i++) begin
            if (load_bank_1) return;
            @(negedge clk);
        end
        chk({name, "_timeout"}, load_bank_1, 1);
    endtask

    task automatic wait_cv(input string name);
        for (int i = 0; i < 30; i++) begin
            if (cascade_valid) return;
            @(negedge clk);
        end
        chk({name, "_timeout"}, cascade_valid, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        // Reset state
        @(negedge clk);
        chk_on = 1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_lb1", load_bank_1, 0);
        chk("rst_cv", cascade_valid, 0);
        chk("rst_nb", next_bank, 0);
        do_reset();

        // 1: single group into bank 1
        for (int i = 1; i <= 3; i++) push(rep(8'(i)));
        s_valid = 0;
        wait_lb1("t1");
        for (int n = 0; n <= 3; n++) begin
            chk($sformatf("t1_lb1_%0d", n), load_bank_1, (n < 3) ? 1 : 0);
            if (n >= 1) chk($sformatf("t1_co_%0d", n), cascade_out, rep(8'(n)));
            chk($sformatf("t1_bl_%0d", n), bank_loaded, (n == 3) ? 2'b01 : 2'b00);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // 2: two back-to-back groups
        do_reset();
        fork
            begin
                for (int i = 1; i <= 6; i++) push(rep(8'(i)));
                s_valid = 0;
            end
            begin
                wait_lb1("t2");
                for (int n = 0; n <= 6; n++) begin
                    chk($sformatf("t2_lb1_%0d", n), load_bank_1, (n < 3) ? 1 : 0);
                    chk($sformatf("t2_lb2_%0d", n), load_bank_2, (n >= 3 && n < 6) ? 1 : 0);
                    chk($sformatf("t2_cv_%0d", n), cascade_valid, (n >= 1) ? 1 : 0);
                    if (n >= 1) chk($sformatf("t2_co_%0d", n), cascade_out, rep(8'(n)));
                    chk($sformatf("t2_bl_%0d", n), bank_loaded,
                        (n == 3) ? 2'b01 : ((n == 6) ? 2'b10 : 2'b00));
                    @(negedge clk);
                end
            end
        join
        repeat (3) @(negedge clk);

        // 3: partial group waits for its third word
        do_reset();
        push(rep(8'h11));
        push(rep(8'h12));
        s_valid = 0;
        repeat (4) @(negedge clk);
        chk("t3_partial_lb1", load_bank_1, 0);
        chk("t3_partial_cv", cascade_valid, 0);
        push(rep(8'h13));
        s_valid = 0;
        chk("t3_lb1_pre", load_bank_1, 0);
        @(negedge clk);
        chk("t3_lb1_start", load_bank_1, 1);
        repeat (6) @(negedge clk);

        // 4: busy bank 1 holds the feeder idle
        do_reset();
        bank_busy = 2'b01;
        for (int i = 0; i < 3; i++) push(rep(8'(8'h20 + i)));
        s_valid = 0;
        repeat (5) @(negedge clk);
        chk("t4_busy_lb1", load_bank_1, 0);
        bank_busy = 2'b00;
        @(negedge clk);
        chk("t4_release_lb1", load_bank_1, 1);
        repeat (6) @(negedge clk);

        // 5: fill to capacity, then drain with pushes overlapping pops
        do_reset();
        bank_busy = 2'b11;
        acc = 0;
        s_valid = 1;
        for (int i = 0; i < 15; i++) begin
            s_data = rep(8'(8'h40 + i));
            if (s_ready) acc++;
            @(negedge clk);
        end
        chk("t5_accepted", acc, 8);
        chk("t5_full_ready", s_ready, 0);
        bank_busy = 2'b10;
        for (int i = 0; i < 12; i++) begin
            s_data = rep(8'(8'h60 + i));
            @(negedge clk);
        end
        s_valid = 0;
        bank_busy = 2'b00;
        repeat (12) @(negedge clk);

        // 6: reset during a group
        do_reset();
        for (int i = 0; i < 3; i++) push(rep(8'(8'h70 + i)));
        s_valid = 0;
        wait_cv("t6");
        #2 rst_n = 0;
        #1;
        chk("t6_rst_s_ready", s_ready, 0);
        chk("t6_rst_lb1", load_bank_1, 0);
        chk("t6_rst_lb2", load_bank_2, 0);
        chk("t6_rst_co", cascade_out, 0);
        chk("t6_rst_cv", cascade_valid, 0);
        chk("t6_rst_bl", bank_loaded, 0);
        chk("t6_rst_nb", next_bank, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (8) @(negedge clk);
        chk("t6_after_nb", next_bank, 0);
        chk("t6_after_cv", cascade_valid, 0);
        chk("t6_after_lb1", load_bank_1, 0);

        // Random traffic, busy changes and occasional mid-cycle resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = {16'($urandom), $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) bank_busy = 2'($urandom);
            if (c % 997 == 500) begin
                #3 rst_n = 0;
                #4 rst_n = 1;
            end
            @(negedge clk);
        end
        s_valid = 0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
